mem_ctrl: RTL

//   CPU-side memory interface. Holds the MAR and MDR and sequences single

---
 rtl/mem_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MAR/MDR holder that sequences single read/write transactions into a synchronous ram
// Outputs are decoded straight from state so the async clear drops every strobe at once.
module mem_ctrl #(
  parameter int BITS     = 32,
  parameter int ADDR     = 9,
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [BITS-1:0] bus_in,
  input  logic            mar_in,
  input  logic            mdr_in,
  input  logic            req,
  input  logic            rnw,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] mdr_out,
  output logic [BITS-1:0] ram_dataIn,
  output logic [ADDR-1:0] ram_address,
  output logic            ram_read,
  output logic            ram_write,
  input  logic [BITS-1:0] ram_dataOut
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_LAT - 1);

  logic [2:0]      r_state;
  logic [ADDR-1:0] r_mar;
  logic [BITS-1:0] r_mdr;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_mar   <= '0;
      r_mdr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // loads land on the same edge as req, so the transaction sees the new values
          if (mar_in) r_mar <= bus_in[ADDR-1:0];
          if (mdr_in) r_mdr <= bus_in;
          if (req) begin
            r_state <= rnw ? S_READ : S_WRITE;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WRITE: r_state <= S_DONE;
        S_READ: begin
          if (r_cnt == '0) r_state <= S_CAPTURE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_mdr   <= ram_dataOut;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign ram_write   = (r_state == S_WRITE);
  assign ram_read    = (r_state == S_READ);
  assign mdr_out     = r_mdr;
  assign ram_dataIn  = r_mdr;
  assign ram_address = r_mar;

endmodule
